// File: rtl/dispatch_buffer_pkg.sv
// Shared dispatch definitions: default field widths and the packed entry layout
// used by both the dispatch buffer and the issue queue.
package dispatch_buffer_pkg;

  localparam int DEF_OPCODE     = 7;
  localparam int DEF_PRF_WIDTH  = 6;
  localparam int DEF_AGE_WIDTH  = 5;
  localparam int DISPATCH_LANES = 4;

  // Entry layout, LSB first: prd, prs2, prs1, prd_v, prs2_v, prs1_v, op
  function automatic int entry_width(input int op_w, input int prf_w);
    return op_w + 3 + 3 * prf_w;
  endfunction

  function automatic int off_prd(input int prf_w);
    return 0 * prf_w;
  endfunction

  function automatic int off_prs2(input int prf_w);
    return prf_w;
  endfunction

  function automatic int off_prs1(input int prf_w);
    return 2 * prf_w;
  endfunction

  function automatic int off_prd_v(input int prf_w);
    return 3 * prf_w;
  endfunction

  function automatic int off_prs2_v(input int prf_w);
    return 3 * prf_w + 1;
  endfunction

  function automatic int off_prs1_v(input int prf_w);
    return 3 * prf_w + 2;
  endfunction

  function automatic int off_op(input int prf_w);
    return 3 * prf_w + 3;
  endfunction

endpackage

// File: rtl/dispatch_entry_mux.sv
// Picks the four entries starting at the head pointer, wrapping around the ring.
module dispatch_entry_mux
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 28,
  parameter int PTR_W   = 3
) (
  input  logic [ENTRY_W-1:0] entries [DEPTH],
  input  logic [PTR_W-1:0]   head,
  output logic [ENTRY_W-1:0] lanes   [DISPATCH_LANES]
);

  logic [PTR_W-1:0] idx;

  // Lane i reads entry head+i; pointer arithmetic wraps naturally at DEPTH.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DISPATCH_LANES; i++) begin
      idx      = head + PTR_W'(i);
      lanes[i] = entries[idx];
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular dispatch buffer between rename and the issue queue. Accepts groups of
// up to four renamed instructions and fires up to four per cycle, bounded by the
// free issue-queue slots, stamping each dispatched instruction with an age.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int OPCODE    = DEF_OPCODE,
  parameter int PRF_WIDTH = DEF_PRF_WIDTH,
  parameter int AGE_WIDTH = DEF_AGE_WIDTH,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [2:0]             in_cnt,
  input  logic [4*OPCODE-1:0]    in_op,
  input  logic [3:0]             in_prs1_v,
  input  logic [3:0]             in_prs2_v,
  input  logic [3:0]             in_prd_v,
  input  logic [4*PRF_WIDTH-1:0] in_prs1,
  input  logic [4*PRF_WIDTH-1:0] in_prs2,
  input  logic [4*PRF_WIDTH-1:0] in_prd,
  output logic                   in_ready,
  input  logic [4:0]             iq_free_cnt,
  output logic [3:0]             out_valid,
  output logic [4*OPCODE-1:0]    out_op,
  output logic [3:0]             out_prs1_v,
  output logic [3:0]             out_prs2_v,
  output logic [3:0]             out_prd_v,
  output logic [4*PRF_WIDTH-1:0] out_prs1,
  output logic [4*PRF_WIDTH-1:0] out_prs2,
  output logic [4*PRF_WIDTH-1:0] out_prd,
  output logic [4*AGE_WIDTH-1:0] out_age
);

  localparam int EW    = entry_width(OPCODE, PRF_WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [EW-1:0]        mem       [DEPTH];
  logic [EW-1:0]        in_entry  [DISPATCH_LANES];
  logic [EW-1:0]        sel_entry [DISPATCH_LANES];
  logic [PTR_W-1:0]     wr_ptr    [DISPATCH_LANES];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic [AGE_WIDTH-1:0] age_cnt;
  logic [2:0]           enq_n, disp_n;
  logic                 enq;
  int                   avail;

  // Acceptance is decided from the registered count only, so a full group always fits.
  always_comb begin
    in_ready = (count <= CNT_W'(DEPTH - 4));
    enq_n    = (in_cnt > 3'd4) ? 3'd4 : in_cnt;
    enq      = in_ready && !flush && (enq_n != 3'd0);
    for (int i = 0; i < DISPATCH_LANES; i++) begin
      wr_ptr[i]   = tail + PTR_W'(i);
      in_entry[i] = {in_op[i*OPCODE +: OPCODE], in_prs1_v[i], in_prs2_v[i], in_prd_v[i],
                     in_prs1[i*PRF_WIDTH +: PRF_WIDTH], in_prs2[i*PRF_WIDTH +: PRF_WIDTH],
                     in_prd[i*PRF_WIDTH +: PRF_WIDTH]};
    end
  end

  // Dispatch width is min(occupancy, free issue slots, 4); a redirect suppresses it.
  always_comb begin
    avail = int'(count);
    if (int'(iq_free_cnt) < avail) avail = int'(iq_free_cnt);
    if (avail > 4) avail = 4;
    disp_n = flush ? 3'd0 : 3'(avail);
  end

  dispatch_entry_mux #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EW),
    .PTR_W   (PTR_W)
  ) u_entry_mux (
    .entries (mem),
    .head    (head),
    .lanes   (sel_entry)
  );

  // Unpack the head-relative entries onto the lanes, zeroing lanes that do not fire.
  always_comb begin
    out_valid  = '0;
    out_op     = '0;
    out_prs1_v = '0;
    out_prs2_v = '0;
    out_prd_v  = '0;
    out_prs1   = '0;
    out_prs2   = '0;
    out_prd    = '0;
    out_age    = '0;
    for (int i = 0; i < DISPATCH_LANES; i++) begin
      if (3'(i) < disp_n) begin
        out_valid[i]                       = 1'b1;
        out_op[i*OPCODE +: OPCODE]         = sel_entry[i][off_op(PRF_WIDTH) +: OPCODE];
        out_prs1_v[i]                      = sel_entry[i][off_prs1_v(PRF_WIDTH)];
        out_prs2_v[i]                      = sel_entry[i][off_prs2_v(PRF_WIDTH)];
        out_prd_v[i]                       = sel_entry[i][off_prd_v(PRF_WIDTH)];
        out_prs1[i*PRF_WIDTH +: PRF_WIDTH] = sel_entry[i][off_prs1(PRF_WIDTH) +: PRF_WIDTH];
        out_prs2[i*PRF_WIDTH +: PRF_WIDTH] = sel_entry[i][off_prs2(PRF_WIDTH) +: PRF_WIDTH];
        out_prd[i*PRF_WIDTH +: PRF_WIDTH]  = sel_entry[i][off_prd(PRF_WIDTH) +: PRF_WIDTH];
        out_age[i*AGE_WIDTH +: AGE_WIDTH]  = age_cnt + AGE_WIDTH'(i);
      end
    end
  end

  // Entry storage is write-only on enqueue and never needs clearing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_LANES; i++) begin
      if (enq && (3'(i) < enq_n)) mem[wr_ptr[i]] <= in_entry[i];
    end
  end

  // Pointer, occupancy and age bookkeeping; flush empties the ring but keeps age running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      age_cnt <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head    <= head + PTR_W'(disp_n);
      tail    <= tail + (enq ? PTR_W'(enq_n) : PTR_W'(0));
      count   <= count + (enq ? CNT_W'(enq_n) : CNT_W'(0)) - CNT_W'(disp_n);
      age_cnt <= age_cnt + AGE_WIDTH'(disp_n);
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_dispatch_buffer;

  localparam int OP  = 7;
  localparam int PRF = 6;
  localparam int AGE = 5;

  typedef struct {
    logic [OP-1:0]  op;
    logic           s1v, s2v, dv;
    logic [PRF-1:0] s1, s2, d;
  } instr_t;

  logic           clk = 1'b0;
  logic           rst, flush;
  logic [2:0]     in_cnt;
  logic [4*OP-1:0]  in_op;
  logic [3:0]     in_prs1_v, in_prs2_v, in_prd_v;
  logic [4*PRF-1:0] in_prs1, in_prs2, in_prd;
  logic           in_ready;
  logic [4:0]     iq_free_cnt;
  logic [3:0]     out_valid, out_prs1_v, out_prs2_v, out_prd_v;
  logic [4*OP-1:0]  out_op;
  logic [4*PRF-1:0] out_prs1, out_prs2, out_prd;
  logic [4*AGE-1:0] out_age;

  instr_t q[$];
  int     age_m;
  int     prd_seq;
  int     passed;
  int     total;

  dispatch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_cnt      (in_cnt),
    .in_op       (in_op),
    .in_prs1_v   (in_prs1_v),
    .in_prs2_v   (in_prs2_v),
    .in_prd_v    (in_prd_v),
    .in_prs1     (in_prs1),
    .in_prs2     (in_prs2),
    .in_prd      (in_prd),
    .in_ready    (in_ready),
    .iq_free_cnt (iq_free_cnt),
    .out_valid   (out_valid),
    .out_op      (out_op),
    .out_prs1_v  (out_prs1_v),
    .out_prs2_v  (out_prs2_v),
    .out_prd_v   (out_prd_v),
    .out_prs1    (out_prs1),
    .out_prs2    (out_prs2),
    .out_prd     (out_prd),
    .out_age     (out_age)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of offered instructions; prd tags are sequential so order is visible.
  task automatic applyStimulus(input int cnt, input int iq, input bit fl);
    in_cnt      = 3'(cnt);
    iq_free_cnt = 5'(iq);
    flush       = fl;
    for (int i = 0; i < 4; i++) begin
      in_op[i*OP +: OP]    = OP'($urandom);
      in_prs1_v[i]         = 1'($urandom);
      in_prs2_v[i]         = 1'($urandom);
      in_prd_v[i]          = 1'($urandom);
      in_prs1[i*PRF +: PRF] = PRF'($urandom);
      in_prs2[i*PRF +: PRF] = PRF'($urandom);
      in_prd[i*PRF +: PRF]  = PRF'(prd_seq + i);
    end
    prd_seq += 4;
  endtask

  function automatic int modelDispatch();
    int n;
    n = q.size();
    if (int'(iq_free_cnt) < n) n = int'(iq_free_cnt);
    if (n > 4) n = 4;
    if (flush) n = 0;
    return n;
  endfunction

  // Compare every output against what the model says this cycle should show.
  task automatic checkOutput(input string tag);
    int n;
    logic [3:0]     e_v, e_s1v, e_s2v, e_dv;
    logic [4*OP-1:0]  e_op;
    logic [4*PRF-1:0] e_s1, e_s2, e_d;
    logic [4*AGE-1:0] e_age;
    #1;
    n = modelDispatch();
    e_v = '0; e_s1v = '0; e_s2v = '0; e_dv = '0;
    e_op = '0; e_s1 = '0; e_s2 = '0; e_d = '0; e_age = '0;
    for (int i = 0; i < n; i++) begin
      e_v[i]             = 1'b1;
      e_op[i*OP +: OP]   = q[i].op;
      e_s1v[i]           = q[i].s1v;
      e_s2v[i]           = q[i].s2v;
      e_dv[i]            = q[i].dv;
      e_s1[i*PRF +: PRF] = q[i].s1;
      e_s2[i*PRF +: PRF] = q[i].s2;
      e_d[i*PRF +: PRF]  = q[i].d;
      e_age[i*AGE +: AGE] = AGE'((age_m + i) % 32);
    end
    checkVal({tag, ".in_ready"},   32'(in_ready),   32'(q.size() <= 4));
    checkVal({tag, ".out_valid"},  32'(out_valid),  32'(e_v));
    checkVal({tag, ".out_op"},     32'(out_op),     32'(e_op));
    checkVal({tag, ".out_prs1_v"}, 32'(out_prs1_v), 32'(e_s1v));
    checkVal({tag, ".out_prs2_v"}, 32'(out_prs2_v), 32'(e_s2v));
    checkVal({tag, ".out_prd_v"},  32'(out_prd_v),  32'(e_dv));
    checkVal({tag, ".out_prs1"},   32'(out_prs1),   32'(e_s1));
    checkVal({tag, ".out_prs2"},   32'(out_prs2),   32'(e_s2));
    checkVal({tag, ".out_prd"},    32'(out_prd),    32'(e_d));
    checkVal({tag, ".out_age"},    32'(out_age),    32'(e_age));
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic stepClock();
    int     n, eff;
    bit     rdy, fl;
    instr_t lane[4];
    n   = modelDispatch();
    rdy = (q.size() <= 4);
    fl  = flush;
    eff = (int'(in_cnt) > 4) ? 4 : int'(in_cnt);
    for (int i = 0; i < 4; i++) begin
      lane[i].op  = in_op[i*OP +: OP];
      lane[i].s1v = in_prs1_v[i];
      lane[i].s2v = in_prs2_v[i];
      lane[i].dv  = in_prd_v[i];
      lane[i].s1  = in_prs1[i*PRF +: PRF];
      lane[i].s2  = in_prs2[i*PRF +: PRF];
      lane[i].d   = in_prd[i*PRF +: PRF];
    end
    @(posedge clk);
    repeat (n) void'(q.pop_front());
    age_m = (age_m + n) % 32;
    if (fl) q.delete();
    else if (rdy) for (int i = 0; i < eff; i++) q.push_back(lane[i]);
    #1;
  endtask

  task automatic cycle(input string tag, input int cnt, input int iq, input bit fl);
    applyStimulus(cnt, iq, fl);
    checkOutput(tag);
    stepClock();
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    age_m   = 0;
    prd_seq = 0;
    rst     = 1'b1;
    applyStimulus(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;
    #1;

    // Group of four, then dispatched together with ages 0..3
    prd_seq = 1;
    cycle("grp4_enq", 4, 16, 0);
    applyStimulus(0, 16, 0);
    checkOutput("grp4_disp");
    checkVal("grp4_valid", 32'(out_valid), 32'h0000000F);
    checkVal("grp4_prd",   32'(out_prd),   {8'd0, 6'd4, 6'd3, 6'd2, 6'd1});
    checkVal("grp4_age",   32'(out_age),   {12'd0, 5'd3, 5'd2, 5'd1, 5'd0});
    stepClock();

    // Fill to eight, then drain two per cycle with in_ready low while above four
    cycle("fill_a", 4, 0, 0);
    cycle("fill_b", 4, 0, 0);
    applyStimulus(4, 2, 0);
    checkOutput("full_iq2");
    checkVal("full_valid", 32'(out_valid), 32'h3);
    checkVal("full_ready", 32'(in_ready),  32'h0);
    stepClock();
    applyStimulus(4, 0, 0);
    checkOutput("six_left");
    checkVal("six_ready", 32'(in_ready), 32'h0);
    stepClock();

    // Flush with six buffered and a group offered
    cycle("flush", 4, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("post_flush");
    checkVal("flush_valid", 32'(out_valid), 32'h0);
    checkVal("flush_ready", 32'(in_ready),  32'h1);
    stepClock();

    // Fill to seven, drain four, refill across the wrap, then drain in order
    cycle("wrap_a", 4, 0, 0);
    cycle("wrap_b", 3, 0, 0);
    cycle("wrap_drain", 0, 4, 0);
    cycle("wrap_refill", 4, 0, 0);
    for (int k = 0; k < 3; k++) cycle("wrap_out", 0, 3, 0);

    // Count five refuses a group; dispatch still proceeds
    cycle("five_a", 4, 0, 0);
    cycle("five_b", 1, 0, 0);
    applyStimulus(4, 1, 0);
    checkOutput("five_offer");
    checkVal("five_ready", 32'(in_ready), 32'h0);
    stepClock();
    for (int k = 0; k < 3; k++) cycle("five_drain", 0, 4, 0);

    // Randomized traffic, including oversize in_cnt, flushes and a mid-run reset
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        rst = 1'b1;
        #1;
        q.delete();
        age_m = 0;
        applyStimulus(0, 16, 0);
        checkOutput("mid_reset");
        rst = 1'b0;
        #1;
      end
      cycle("rand", $urandom_range(0, 7),
            ($urandom_range(0, 3) == 0) ? 16 : $urandom_range(0, 16),
            ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 Parameter OPCODE, default 7, opcode width per instruction.
REQ-002 Parameter PRF_WIDTH, default 6, physical register tag width.
REQ-003 Parameter AGE_WIDTH, default 5, age stamp width written into issue queue entries.
REQ-004 Parameter DEPTH, default 8, buffer entries; power of two, >= 4.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  discard all buffered instructions (redirect).
REQ-008 in_cnt  input  3  number of renamed instructions offered this cycle, 0..4, occupying lanes 0..in_cnt-1.
REQ-009 in_op  input  4*OPCODE  lane i opcode at [i*OPCODE +: OPCODE]; same lane packing for all 4-lane buses.
REQ-010 in_prs1_v, in_prs2_v, in_prd_v  input  4 each  per-lane operand/destination valid.
REQ-011 in_prs1, in_prs2, in_prd  input  4*PRF_WIDTH each  per-lane physical tags.
REQ-012 in_ready  output  1  buffer can accept a full group of 4 this cycle.
REQ-013 iq_free_cnt  input  5  free issue-queue entries this cycle, 0..16.
REQ-014 out_valid  output  4  per-lane dispatch strobe to issue queue; always lower-lane contiguous.
REQ-015 out_op, out_prs1_v, out_prs2_v, out_prd_v, out_prs1, out_prs2, out_prd  output  same widths as inputs  dispatched fields per lane.
REQ-016 out_age  output  4*AGE_WIDTH  age stamp per dispatched lane.

Function
REQ-017 Buffer SHALL be a circular FIFO with head/tail pointers (log2 DEPTH bits, wrapping) and count (0..DEPTH).
REQ-018 in_ready SHALL be 1 iff registered count <= DEPTH-4, independent of same-cycle dequeue.
REQ-019 Enqueue SHALL occur iff in_ready=1, flush=0 and in_cnt>0; lanes 0..in_cnt-1 written at tail..tail+in_cnt-1 in lane order; in_cnt>4 treated as 4.
REQ-020 Offered instructions with in_ready=0 SHALL be ignored; producer holds them.
REQ-021 Dispatch count n SHALL equal min(count, iq_free_cnt, 4), computed from registered state; flush=1 forces n=0.
REQ-022 out_valid SHALL equal lanes 0..n-1 set; lane i carries entry head+i (mod DEPTH); invalid lanes output zeros.
REQ-023 Dispatch SHALL be fire-and-forget: entries with out_valid=1 are retired at the same clock edge, no acknowledge.
REQ-024 Latency: instruction enqueued at edge t SHALL be dispatchable no earlier than cycle after t (no bypass).
REQ-025 Simultaneous enqueue and dequeue SHALL update count by in_cnt-n in one cycle.
REQ-026 Age counter (AGE_WIDTH bits) SHALL stamp lane i with age_cnt+i mod 2^AGE_WIDTH and advance by n per cycle, wrapping.
REQ-027 flush SHALL set head=tail=0, count=0 at next edge, dropping same-cycle enqueue; age counter not cleared.
REQ-028 Ordering: dispatch order SHALL equal enqueue order across pointer wrap.

Reset
REQ-029 On rst: head=0, tail=0, count=0, age counter=0; out_valid=0, all out_* fields 0, in_ready=1; entry storage need not be cleared.
REQ-030 rst asserted mid-operation SHALL drop all buffered instructions immediately.

Structure
REQ-031 Shared package SHALL hold OPCODE, PRF_WIDTH, AGE_WIDTH defaults and the entry-field layout constants, shared with issue queue.
REQ-032 One sub-module, dispatch_entry_mux, SHALL select the 4 head-relative entries; everything else in dispatch_buffer.

Verification
REQ-033 Reset then in_cnt=4 with prd=1,2,3,4, iq_free_cnt=16 -> next cycle out_valid=1111, out_prd lanes 1..4, out_age 0..3.
REQ-034 8 entries buffered, iq_free_cnt=2 -> out_valid=0011, count 6 next cycle; in_ready=0 while count>4.
REQ-035 Fill to 7, drain 4, enqueue 4 across pointer wrap -> dispatch order preserved, tail wraps to 3.
REQ-036 count=5, in_cnt=4 offered -> in_ready=0, no enqueue, count unchanged apart from dispatch.
REQ-037 Dispatch 33 instructions -> out_age wraps 31 to 0.
REQ-038 flush with in_cnt=4 and count=6 -> count=0 next cycle, out_valid=0, in_ready=1.
